// File: rtl/pipelined_wallace_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_wallace_mult : 3-stage WA x WB Wallace-tree multiplier with valid/ready handshake.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_wallace_mult #(
  parameter int WA    = 8,
  parameter int WB    = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WA-1:0]      in_a,
  input  logic [WB-1:0]      in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WA+WB-1:0]   out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W      = WA + WB;
  localparam int H      = W + 2;
  localparam int LEVELS = W;

  logic             stall;
  logic             v1, v2, v3;
  logic [WA-1:0]    a1;
  logic [WB-1:0]    b1;
  logic             sg1;
  logic [TAG_W-1:0] tag1, tag2;
  logic [W-1:0]     sum2, carry2;
  logic [W-1:0]     row_s, row_c;
  logic [W-1:0]     rca_sum;
  logic [W-1:0]     rca_c;

  assign stall     = v3 && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3;

  // Column-wise bit heaps; heights depend only on parameters and fold to constants.
  logic [H-1:0] cols [W];
  logic [H-1:0] nxt  [W];
  int           cnt  [W];
  int           ncnt [W];
  logic [2:0]   win;
  logic         fx, fy, fz, fs, fc;
  int           cn;

  always_comb begin
    win = '0;
    fx  = 1'b0;
    fy  = 1'b0;
    fz  = 1'b0;
    fs  = 1'b0;
    fc  = 1'b0;
    cn  = 0;
    row_s = '0;
    row_c = '0;
    for (int c = 0; c < W; c++) begin
      cols[c] = '0;
      nxt[c]  = '0;
      cnt[c]  = 0;
      ncnt[c] = 0;
    end

    // Baugh-Wooley: invert cross terms that involve exactly one sign bit (signed mode only).
    for (int i = 0; i < WB; i++) begin
      for (int j = 0; j < WA; j++) begin
        fx = (a1[j] & b1[i]) ^ (sg1 & ((i == WB - 1) != (j == WA - 1)));
        cols[i+j] = cols[i+j] | (H'(fx) << cnt[i+j]);
        cnt[i+j]  = cnt[i+j] + 1;
      end
    end
    cols[WA-1] = cols[WA-1] | (H'(sg1) << cnt[WA-1]);
    cnt[WA-1]  = cnt[WA-1] + 1;
    cols[WB-1] = cols[WB-1] | (H'(sg1) << cnt[WB-1]);
    cnt[WB-1]  = cnt[WB-1] + 1;
    cols[W-1]  = cols[W-1] | (H'(sg1) << cnt[W-1]);
    cnt[W-1]   = cnt[W-1] + 1;

    for (int l = 0; l < LEVELS; l++) begin
      for (int c = 0; c < W; c++) begin
        nxt[c]  = '0;
        ncnt[c] = 0;
      end
      for (int c = 0; c < W; c++) begin
        cn = (c + 1 < W) ? c + 1 : c;
        for (int k = 0; k < H; k += 3) begin
          win = 3'(cols[c] >> k);
          fx  = win[0];
          fy  = win[1];
          fz  = win[2];
          if (k + 2 < cnt[c]) begin
            fs = fx ^ fy ^ fz;
            fc = (fx & fy) | (fz & (fx ^ fy));
            nxt[c]  = nxt[c] | (H'(fs) << ncnt[c]);
            ncnt[c] = ncnt[c] + 1;
            if (c + 1 < W) begin
              nxt[cn]  = nxt[cn] | (H'(fc) << ncnt[cn]);
              ncnt[cn] = ncnt[cn] + 1;
            end
          end else if ((k + 1 < cnt[c]) && (cnt[c] > 2)) begin
            fs = fx ^ fy;
            fc = fx & fy;
            nxt[c]  = nxt[c] | (H'(fs) << ncnt[c]);
            ncnt[c] = ncnt[c] + 1;
            if (c + 1 < W) begin
              nxt[cn]  = nxt[cn] | (H'(fc) << ncnt[cn]);
              ncnt[cn] = ncnt[cn] + 1;
            end
          end else begin
            // Columns already at height <= 2 (or leftovers) pass straight through.
            if (k < cnt[c]) begin
              nxt[c]  = nxt[c] | (H'(fx) << ncnt[c]);
              ncnt[c] = ncnt[c] + 1;
            end
            if (k + 1 < cnt[c]) begin
              nxt[c]  = nxt[c] | (H'(fy) << ncnt[c]);
              ncnt[c] = ncnt[c] + 1;
            end
          end
        end
      end
      for (int c = 0; c < W; c++) begin
        cols[c] = nxt[c];
        cnt[c]  = ncnt[c];
      end
    end

    for (int c = 0; c < W; c++) begin
      row_s[c] = cols[c][0];
      row_c[c] = cols[c][1];
    end
  end

  // Final ripple-carry add; the carry out of the top bit is dropped.
  assign rca_c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_rca
    assign rca_sum[i] = sum2[i] ^ carry2[i] ^ rca_c[i];
    if (i < W - 1) begin : g_carry
      assign rca_c[i+1] = (sum2[i] & carry2[i]) | (rca_c[i] & (sum2[i] ^ carry2[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v2) begin
        out_product <= rca_sum;
        out_tag     <= tag2;
      end
    end
  end

  // Data registers only move with a valid source, so idle X inputs never reach the output.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        a1   <= in_a;
        b1   <= in_b;
        sg1  <= in_signed;
        tag1 <= in_tag;
      end
      if (v1) begin
        sum2   <= row_s;
        carry2 <= row_c;
        tag2   <= tag1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_wallace_mult.sv
`default_nettype none
// Bench for pipelined_wallace_mult: 8x8 directed/stream/backpressure/reset, 4x4 exhaustive sweep.
module tb_pipelined_wallace_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, s8, r8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] p8;

  logic        v4, s4, r4, ir4, ov4;
  logic [3:0]  a4, b4;
  logic [3:0]  t4, ot4;
  logic [7:0]  p4;

  pipelined_wallace_mult #(.WA(8), .WB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .in_tag(t8), .out_valid(ov8), .out_ready(r8),
    .out_product(p8), .out_tag(ot8)
  );

  pipelined_wallace_mult #(.WA(4), .WB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .in_tag(t4), .out_valid(ov4), .out_ready(r4),
    .out_product(p4), .out_tag(ot4)
  );

  typedef struct {
    logic [15:0] p;
    logic [3:0]  t;
    int          st;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int out8     = 0;
  int out4     = 0;
  logic lat_chk = 1'b1;

  logic        obs8_valid, obs8_ready, obs4_ready;
  logic [15:0] obs8_prod;
  logic [3:0]  obs8_tag;

  // Reference: plain integer multiply of the (optionally sign-extended) operands.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input int wa, input int wb, input logic s);
    longint xa, xb, p;
    xa = longint'(a);
    xb = longint'(b);
    if (s && a[wa-1]) xa = xa - (longint'(1) << wa);
    if (s && b[wb-1]) xb = xb - (longint'(1) << wb);
    p = xa * xb;
    p = p & ((longint'(1) << (wa + wb)) - 1);
    return 16'(p);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    obs8_valid = ov8;
    obs8_prod  = p8;
    obs8_tag   = ot8;
    obs8_ready = ir8;
    obs4_ready = ir4;
    if (!rst) begin
      if (ov8 === 1'b1 && r8) begin
        if (q8.size() == 0) chk("unexpected_out8", 64'(ov8), 0);
        else begin
          e = q8.pop_front();
          chk("prod8", p8, e.p);
          chk("tag8", ot8, e.t);
          if (lat_chk) chk("latency8", cyc - e.st, 3);
          out8++;
        end
      end
      if (ov4 === 1'b1 && r4) begin
        if (q4.size() == 0) chk("unexpected_out4", 64'(ov4), 0);
        else begin
          e = q4.pop_front();
          chk("prod4", p4, e.p);
          chk("tag4", ot4, e.t);
          out4++;
        end
      end
      if (v8 && ir8 === 1'b1) q8.push_back('{ref_mul(a8, b8, 8, 8, s8), t8, cyc});
      if (v4 && ir4 === 1'b1) q4.push_back('{ref_mul({4'b0, a4}, {4'b0, b4}, 4, 4, s4), t4, cyc});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q8.delete();
      q4.delete();
    end
    cyc++;
  endtask

  task automatic dir8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic [15:0] exp);
    v8 = 1'b1; a8 = a; b8 = b; s8 = s; t8 = t; r8 = 1'b1;
    step();
    v8 = 1'b0; a8 = 'x; b8 = 'x; t8 = 'x;
    step();
    step();
    chk("dir_early_valid", obs8_valid, 0);
    step();
    chk("dir_valid", obs8_valid, 1);
    chk("dir_prod", obs8_prod, exp);
    chk("dir_tag", obs8_tag, t);
  endtask

  task automatic rand_op8();
    v8 = 1'b1;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    s8 = 1'($urandom);
    t8 = 4'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] held_p;
    logic [3:0]  held_t;
    int idx, guard;

    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; t8 = '0; r8 = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; t4 = '0; r4 = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", obs8_valid, 0);
    chk("reset_out_product", obs8_prod, 0);
    chk("reset_out_tag", obs8_tag, 0);
    chk("reset_in_ready", obs8_ready, 1);

    // Directed corner values
    dir8(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01);
    dir8(8'h00, 8'hFF, 1'b0, 4'd5, 16'h0000);
    dir8(8'h80, 8'h80, 1'b1, 4'd6, 16'h4000);
    dir8(8'hFF, 8'h01, 1'b1, 4'd7, 16'hFFFF);
    dir8(8'hFF, 8'h01, 1'b0, 4'd8, 16'h00FF);
    dir8(8'h7F, 8'h80, 1'b1, 4'd9, 16'hC080);

    // Back-to-back random stream
    out8 = 0;
    for (int n = 0; n < 64; n++) begin
      rand_op8();
      step();
    end
    v8 = 1'b0;
    repeat (4) step();
    chk("stream_count", out8, 64);
    chk("stream_drained", q8.size(), 0);

    // Backpressure: three ops in flight, a fourth waiting, consumer stalls 5 cycles
    lat_chk = 1'b0;
    out8 = 0;
    for (int n = 0; n < 3; n++) begin
      rand_op8();
      step();
    end
    rand_op8();
    r8 = 1'b0;
    step();
    held_p = obs8_prod;
    held_t = obs8_tag;
    chk("bp_valid", obs8_valid, 1);
    chk("bp_in_ready", obs8_ready, 0);
    chk("bp_head_prod", obs8_prod, q8[0].p);
    chk("bp_head_tag", obs8_tag, q8[0].t);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("bp_in_ready", obs8_ready, 0);
      chk("bp_hold_prod", obs8_prod, held_p);
      chk("bp_hold_tag", obs8_tag, held_t);
    end
    r8 = 1'b1;
    step();
    v8 = 1'b0;
    repeat (6) step();
    chk("bp_count", out8, 4);
    chk("bp_drained", q8.size(), 0);
    lat_chk = 1'b1;

    // Reset with three ops in flight
    for (int n = 0; n < 3; n++) begin
      rand_op8();
      step();
    end
    v8 = 1'b0;
    r8 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    r8 = 1'b1;
    out8 = 0;
    step();
    chk("midrst_out_valid", obs8_valid, 0);
    chk("midrst_out_product", obs8_prod, 0);
    chk("midrst_in_ready", obs8_ready, 1);
    repeat (5) step();
    chk("midrst_no_emit", out8, 0);

    // 4x4 exhaustive sweep, both modes, random valid gaps and consumer stalls
    lat_chk = 1'b0;
    out4 = 0;
    idx = 0;
    guard = 0;
    while (idx < 512 && guard < 6000) begin
      v4 = ($urandom_range(0, 3) != 0);
      a4 = idx[3:0];
      b4 = idx[7:4];
      s4 = idx[8];
      t4 = 4'(idx * 7);
      r4 = ($urandom_range(0, 3) != 0);
      step();
      if (v4 && obs4_ready === 1'b1) idx++;
      guard++;
    end
    chk("sweep_issued", idx, 512);
    v4 = 1'b0;
    guard = 0;
    while (q4.size() != 0 && guard < 200) begin
      r4 = ($urandom_range(0, 1) != 0);
      step();
      guard++;
    end
    chk("sweep_out_count", out4, 512);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
